regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port (write_enable, a3, wd3) between NUM_REQ writeback sources, such as the ALU, load unit and CSR unit. Arbitration is round-robin. A valid/ready handshake is used per requester. The output stage is registered and drives the register-file write port directly. Writes to x0 are accepted and discarded. A saturating counter records arbitration stall cycles for performance debug.

---
 rtl/rv_regfile_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_regfile_pkg.sv
// Shared register-file constants and helpers for the
// writeback path.
package rv_regfile_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_CSR  = 2;

  function automatic logic [3:0] popcount8(
    input logic [7:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: search starts one past
// the previous winner and wraps around.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0]   pos;
  logic [IW-1:0] sel;
  logic          found;

  // first requester after last_i in circular order wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    sel     = '0;
    for (int k = 1; k <= N; k++) begin
      pos = {1'b0, last_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      sel = pos[IW-1:0];
      if (!found && req_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        idx_o        = sel;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port among
// writeback sources, with a registered write stage.
module regfile_wb_arbiter
  import rv_regfile_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REQ         = 3,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [5*NUM_REQ-1:0]          req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          write_enable,
  output logic [4:0]                    a3,
  output logic [DATA_WIDTH-1:0]         wd3,
  output logic [2:0]                    grant_id,
  output logic [STALL_CNT_WIDTH-1:0]    stall_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = REG_ADDR_WIDTH;
  localparam int SW = STALL_CNT_WIDTH;

  logic [IW-1:0]         last_q, last_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         a3_q, a3_d;
  logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
  logic [2:0]            gid_q, gid_d;
  logic [SW-1:0]         stall_q, stall_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         gidx;
  logic                  xfer;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REQ-1:0]    denied;
  logic [3:0]            denied_cnt;
  logic [SW:0]           stall_sum;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign req_ready  = reset ? '0 : grant;
  assign xfer       = |(req_valid & req_ready);
  assign sel_addr   = req_addr[int'(gidx)*AW +: AW];
  assign sel_data   = req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign denied     = req_valid & ~req_ready;
  assign denied_cnt = popcount8(8'(denied));

  // next write stage, pointer and saturating stall count
  always_comb begin
    last_d = last_q;
    we_d   = 1'b0;
    a3_d   = a3_q;
    wd3_d  = wd3_q;
    gid_d  = gid_q;
    if (xfer) begin
      last_d = gidx;
      if (sel_addr != ZERO_REG) begin
        we_d  = 1'b1;
        a3_d  = sel_addr;
        wd3_d = sel_data;
        gid_d = 3'(gidx);
      end
    end
    stall_sum = {1'b0, stall_q} + (SW+1)'(denied_cnt);
    stall_d   = stall_sum[SW] ? '1 : stall_sum[SW-1:0];
  end

  // state registers; reset parks the pointer on the last slot
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= IW'(NUM_REQ-1);
      we_q    <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
      gid_q   <= '0;
      stall_q <= '0;
    end else begin
      last_q  <= last_d;
      we_q    <= we_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
      gid_q   <= gid_d;
      stall_q <= stall_d;
    end
  end

  assign write_enable = we_q;
  assign a3           = a3_q;
  assign wd3          = wd3_q;
  assign grant_id     = gid_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus
// random traffic against a queue-free behavioural model.
module tb_regfile_wb_arbiter;
  import rv_regfile_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_addr;
  logic [DW*N-1:0] req_data;

  logic [N-1:0]    req_ready;
  logic            write_enable;
  logic [4:0]      a3;
  logic [DW-1:0]   wd3;
  logic [2:0]      grant_id;
  logic [15:0]     stall_count;

  logic [N-1:0]    req_ready4;
  logic            write_enable4;
  logic [4:0]      a3_4;
  logic [DW-1:0]   wd3_4;
  logic [2:0]      grant_id4;
  logic [3:0]      stall_count4;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_ptr;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  logic [2:0]  m_gid;
  int          m_stall;
  int          m_stall4;

  regfile_wb_arbiter #(
    .DATA_WIDTH      (DW),
    .NUM_REQ         (N),
    .STALL_CNT_WIDTH (16)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .write_enable (write_enable),
    .a3           (a3),
    .wd3          (wd3),
    .grant_id     (grant_id),
    .stall_count  (stall_count)
  );

  regfile_wb_arbiter #(
    .DATA_WIDTH      (DW),
    .NUM_REQ         (N),
    .STALL_CNT_WIDTH (4)
  ) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready4),
    .write_enable (write_enable4),
    .a3           (a3_4),
    .wd3          (wd3_4),
    .grant_id     (grant_id4),
    .stall_count  (stall_count4)
  );

  always #5 clk = ~clk;

  function automatic int ref_grant();
    if (reset) return -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_edge();
    int g;
    int den;
    g = ref_grant();
    if (reset) begin
      m_ptr    = N - 1;
      m_we     = 1'b0;
      m_a3     = '0;
      m_wd3    = '0;
      m_gid    = '0;
      m_stall  = 0;
      m_stall4 = 0;
    end else begin
      den = $countones(req_valid) - ((g >= 0) ? 1 : 0);
      m_we = 1'b0;
      if (g >= 0) begin
        m_ptr = g;
        if (req_addr[5*g +: 5] != 5'd0) begin
          m_we  = 1'b1;
          m_a3  = req_addr[5*g +: 5];
          m_wd3 = req_data[DW*g +: DW];
          m_gid = 3'(g);
        end
      end
      m_stall  = (m_stall + den > 65535) ? 65535 : m_stall + den;
      m_stall4 = (m_stall4 + den > 15) ? 15 : m_stall4 + den;
    end
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v,
                         input logic [4:0] a,
                         input logic [31:0] d);
    req_valid[i]        = v;
    req_addr[5*i +: 5]  = a;
    req_data[DW*i +: DW] = d;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    advance();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    req_addr  = '1;
    req_data  = '1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    advance();
    n_checks++;
    if ({write_enable, a3, wd3, grant_id} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outs: we=%b a3=%0d wd3=%h gid=%0d want 0",
               write_enable, a3, wd3, grant_id);
    end
    n_checks++;
    if (stall_count !== 16'd0 || stall_count4 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_stall: got %0d/%0d want 0/0",
               stall_count, stall_count4);
    end
    req_valid = '0;
    advance();
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_req(WB_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 001", req_ready);
    end
    advance();
    req_valid = '0;
    n_checks++;
    if ({write_enable, a3, wd3, grant_id} !==
        {1'b1, 5'd5, 32'hDEADBEEF, 3'd0}) begin
      n_fail++;
      $display("FAIL single_write: we=%b a3=%0d wd3=%h gid=%0d want 1/5/deadbeef/0",
               write_enable, a3, wd3, grant_id);
    end
    advance();
    n_checks++;
    if ({write_enable, a3, wd3} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL single_hold: we=%b a3=%0d wd3=%h want 0/5/deadbeef",
               write_enable, a3, wd3);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 5'(i + 1), $urandom);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== onehot(c % N) ||
          req_ready !== onehot(ref_grant())) begin
        n_fail++;
        $display("FAIL fair_ready[%0d]: got %b want %b",
                 c, req_ready, onehot(c % N));
      end
      advance();
      n_checks++;
      if ({write_enable, a3, wd3, grant_id} !==
          {m_we, m_a3, m_wd3, m_gid} || a3 !== 5'(c % N + 1)) begin
        n_fail++;
        $display("FAIL fair_write[%0d]: we=%b a3=%0d gid=%0d want %b/%0d/%0d",
                 c, write_enable, a3, grant_id, m_we, m_a3, m_gid);
      end
    end
    req_valid = '0;
    n_checks++;
    if (stall_count !== 16'd12 || stall_count !== 16'(m_stall)) begin
      n_fail++;
      $display("FAIL fair_stall: got %0d want 12", stall_count);
    end
  endtask

  task automatic test_x0();
    set_req(WB_LOAD, 1'b1, 5'd0, 32'h1234);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL x0_ready: got %b want 010", req_ready);
    end
    advance();
    req_valid = '0;
    n_checks++;
    if (write_enable !== 1'b0 || a3 !== 5'd3 || grant_id !== 3'd2) begin
      n_fail++;
      $display("FAIL x0_drop: we=%b a3=%0d gid=%0d want 0/3/2",
               write_enable, a3, grant_id);
    end
    set_req(WB_LOAD, 1'b1, 5'd11, 32'hAAAA0011);
    set_req(WB_CSR, 1'b1, 5'd12, 32'hBBBB0012);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL x0_ptr_ready: got %b want 100", req_ready);
    end
    advance();
    req_valid[WB_CSR] = 1'b0;
    n_checks++;
    if ({write_enable, a3, wd3, grant_id} !==
        {1'b1, 5'd12, 32'hBBBB0012, 3'd2}) begin
      n_fail++;
      $display("FAIL x0_ptr_write: we=%b a3=%0d gid=%0d want 1/12/2",
               write_enable, a3, grant_id);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL x0_next_ready: got %b want 010", req_ready);
    end
    advance();
    req_valid = '0;
    n_checks++;
    if ({write_enable, a3, wd3, grant_id} !==
        {m_we, m_a3, m_wd3, m_gid} || a3 !== 5'd11) begin
      n_fail++;
      $display("FAIL x0_next_write: we=%b a3=%0d gid=%0d want 1/11/1",
               write_enable, a3, grant_id);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = m_stall;
    for (int c = 0; c < 4; c++) begin
      set_req(WB_CSR, 1'b1, 5'(7 + c), $urandom);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 3'b100) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b want 100", c, req_ready);
      end
      advance();
      n_checks++;
      if ({write_enable, a3, wd3, grant_id} !==
          {m_we, m_a3, m_wd3, m_gid} ||
          write_enable !== 1'b1 || a3 !== 5'(7 + c)) begin
        n_fail++;
        $display("FAIL b2b_write[%0d]: we=%b a3=%0d want 1/%0d",
                 c, write_enable, a3, 7 + c);
      end
    end
    req_valid = '0;
    n_checks++;
    if (stall_count !== 16'(s0)) begin
      n_fail++;
      $display("FAIL b2b_stall: got %0d want %0d", stall_count, s0);
    end
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 5'(20 + i), $urandom);
    end
    for (int c = 0; c < 10; c++) begin
      advance();
      n_checks++;
      if (stall_count4 !== 4'(m_stall4) ||
          stall_count !== 16'(m_stall)) begin
        n_fail++;
        $display("FAIL sat_step[%0d]: got %0d/%0d want %0d/%0d",
                 c, stall_count4, stall_count, m_stall4, m_stall);
      end
    end
    advance();
    req_valid = '0;
    n_checks++;
    if (stall_count4 !== 4'd15 || stall_count !== 16'd22) begin
      n_fail++;
      $display("FAIL sat_final: got %0d/%0d want 15/22",
               stall_count4, stall_count);
    end
  endtask

  task automatic test_reset_midop();
    set_req(WB_ALU, 1'b1, 5'd9, 32'hCAFEF00D);
    advance();
    set_req(WB_LOAD, 1'b1, 5'd13, 32'h13);
    set_req(WB_CSR, 1'b1, 5'd14, 32'h14);
    n_checks++;
    if (write_enable !== 1'b1 || a3 !== 5'd9) begin
      n_fail++;
      $display("FAIL mid_write: we=%b a3=%0d want 1/9", write_enable, a3);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_ready: got %b want 000", req_ready);
    end
    advance();
    n_checks++;
    if ({write_enable, a3, wd3} !== 38'd0 || stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: we=%b a3=%0d wd3=%h stall=%0d want 0",
               write_enable, a3, wd3, stall_count);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_first: got %b want 001", req_ready);
    end
    advance();
    req_valid = '0;
    n_checks++;
    if (grant_id !== 3'd0 || a3 !== 5'd9) begin
      n_fail++;
      $display("FAIL mid_grant: gid=%0d a3=%0d want 0/9", grant_id, a3);
    end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(1, 0) == 1)) begin
          set_req(i, 1'b1,
                  ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom),
                  $urandom);
        end
      end
      @(negedge clk);
      g = ref_grant();
      n_checks++;
      if (req_ready !== onehot(g)) begin
        n_fail++;
        $display("FAIL rnd_ready[%0d]: got %b want %b",
                 c, req_ready, onehot(g));
      end
      advance();
      if (g >= 0) req_valid[g] = 1'b0;
      n_checks++;
      if ({write_enable, a3, wd3, grant_id} !==
          {m_we, m_a3, m_wd3, m_gid} ||
          stall_count !== 16'(m_stall) ||
          stall_count4 !== 4'(m_stall4)) begin
        n_fail++;
        $display("FAIL rnd_out[%0d]: we=%b a3=%0d wd3=%h gid=%0d st=%0d want %b/%0d/%h/%0d/%0d",
                 c, write_enable, a3, wd3, grant_id, stall_count,
                 m_we, m_a3, m_wd3, m_gid, m_stall);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_x0();
    test_back_to_back();
    test_saturation();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
